// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter and its result FIFO.
package wb_pkg;

  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [4:0] addr);
    logic [REG_COUNT-1:0] r;
    r       = '0;
    r[addr] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer and register-file write-port bundle for wb_arbiter.
// Optional forwarding lookup port exists only when WB_ARBITER_FWD_EN is defined.
interface wb_arbiter_if;

  // Handshake: a result transfers on a cycle where *_valid and *_ready are both 1;
  // a producer seeing ready=0 holds valid, addr and data unchanged into the next cycle.
  logic        i_a_valid;
  logic [4:0]  i_a_addr;
  logic [31:0] i_a_data;
  logic        o_a_ready;
  logic        i_b_valid;
  logic [4:0]  i_b_addr;
  logic [31:0] i_b_data;
  logic        o_b_ready;
  logic        i_stall;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [31:0] o_pending;
  logic        o_full;
  logic        o_empty;
`ifdef WB_ARBITER_FWD_EN
  logic [4:0]  i_fwd_addr;
  logic        o_fwd_hit;
  logic [31:0] o_fwd_data;

  modport master (
    output i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data, i_stall, i_fwd_addr,
    input  o_a_ready, o_b_ready, o_rd_wren, o_rd_addr, o_rd_data, o_pending, o_full, o_empty,
           o_fwd_hit, o_fwd_data
  );

  modport slave (
    input  i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data, i_stall, i_fwd_addr,
    output o_a_ready, o_b_ready, o_rd_wren, o_rd_addr, o_rd_data, o_pending, o_full, o_empty,
           o_fwd_hit, o_fwd_data
  );
`else
  modport master (
    output i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data, i_stall,
    input  o_a_ready, o_b_ready, o_rd_wren, o_rd_addr, o_rd_data, o_pending, o_full, o_empty
  );

  modport slave (
    input  i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data, i_stall,
    output o_a_ready, o_b_ready, o_rd_wren, o_rd_addr, o_rd_data, o_pending, o_full, o_empty
  );
`endif

endinterface

// File: rtl/wb_arbiter_fifo.sv
// In-order result FIFO for write-back; exposes per-entry valid/contents and the
// read pointer so the parent can build the pending scoreboard and forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  pop_i,
  output wb_req_t               head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
  output logic [DEPTH-1:0]      valid_o,
  output wb_req_t [DEPTH-1:0]   entries_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic                do_push, do_pop;

  always_comb begin
    // Guard here as well so a misbehaving parent cannot corrupt the pointers.
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = push_req_i;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign rd_ptr_o  = rd_ptr_q;
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU (A) over LSU (B) with anti-starvation,
// zero-latency bypass when idle, FIFO buffering under stall, pending-write scoreboard.
// Define WB_ARBITER_FWD_EN to add the buffered-result forwarding lookup.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  wb_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]       starve_q, starve_d;
  logic                b_prio, grant_a, grant_b, win_valid, win_x0;
  logic                accept, bypass, push, pop;
  wb_req_t             win_req, head_req;
  logic                fifo_full, fifo_empty;
  logic [PW-1:0]       rd_ptr;
  logic [DEPTH-1:0]    ent_valid;
  wb_req_t [DEPTH-1:0] ent;
  logic [REG_COUNT-1:0] pending;

  always_comb begin
    b_prio    = bus.i_b_valid && (starve_q == SW'(STARVE_MAX));
    grant_b   = bus.i_b_valid && (b_prio || !bus.i_a_valid);
    grant_a   = bus.i_a_valid && !grant_b;
    win_valid = grant_a || grant_b;
    win_req.addr = grant_b ? bus.i_b_addr : bus.i_a_addr;
    win_req.data = grant_b ? bus.i_b_data : bus.i_a_data;
    win_x0    = (win_req.addr == 5'd0);
    // x0 results need no slot, so they are taken even when the FIFO is full.
    accept    = i_reset && win_valid && (win_x0 || !fifo_full);
    bypass    = accept && !win_x0 && fifo_empty && !bus.i_stall;
    push      = accept && !win_x0 && !bypass;
    pop       = i_reset && !fifo_empty && !bus.i_stall;
  end

  always_comb begin
    if (!bus.i_b_valid || grant_b) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .push_i     (push),
    .push_req_i (win_req),
    .pop_i      (pop),
    .head_o     (head_req),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .rd_ptr_o   (rd_ptr),
    .valid_o    (ent_valid),
    .entries_o  (ent)
  );

  always_comb begin
    bus.o_a_ready = accept && grant_a;
    bus.o_b_ready = accept && grant_b;
    bus.o_rd_wren = pop || bypass;
    // Buffered head always goes first; bypass only exists when the FIFO is empty.
    if (pop) begin
      bus.o_rd_addr = head_req.addr;
      bus.o_rd_data = head_req.data;
    end else if (bypass) begin
      bus.o_rd_addr = win_req.addr;
      bus.o_rd_data = win_req.data;
    end else begin
      bus.o_rd_addr = '0;
      bus.o_rd_data = '0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending = pending | reg_onehot(ent[i].addr);
    end
    pending[0] = 1'b0;
  end

  assign bus.o_pending = pending;
  assign bus.o_full    = fifo_full;
  assign bus.o_empty   = fifo_empty;

`ifdef WB_ARBITER_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic          fwd_hit;
  logic [31:0]   fwd_data;

  always_comb begin
    fwd_idx  = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    // Walk oldest to youngest so the last match seen is the youngest one.
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (ent_valid[fwd_idx] && (ent[fwd_idx].addr == bus.i_fwd_addr) &&
          (bus.i_fwd_addr != 5'd0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent[fwd_idx].data;
      end
    end
  end

  assign bus.o_fwd_hit  = fwd_hit;
  assign bus.o_fwd_data = fwd_data;
`else
  logic unused_rd_ptr;
  assign unused_rd_ptr = ^rd_ptr;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle-by-cycle vector table plus reset,
// starvation and forwarding sequences.
module tb_wb_arbiter;
  import wb_pkg::*;

  typedef struct {
    string       name;
    logic        stall;
    logic        a_v;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_v;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [4:0]  fwd_addr;
    logic        e_a_rdy;
    logic        e_b_rdy;
    logic        e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_full;
    logic        e_empty;
    logic        e_hit;
    logic [31:0] e_fwd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic a_v, input logic [4:0] a_addr,
                       input logic [31:0] a_data, input logic b_v, input logic [4:0] b_addr,
                       input logic [31:0] b_data, input logic [4:0] fwd_addr);
    bus.i_stall   = stall;
    bus.i_a_valid = a_v;
    bus.i_a_addr  = a_addr;
    bus.i_a_data  = a_data;
    bus.i_b_valid = b_v;
    bus.i_b_addr  = b_addr;
    bus.i_b_data  = b_data;
`ifdef WB_ARBITER_FWD_EN
    bus.i_fwd_addr = fwd_addr;
`else
    if (fwd_addr != 5'd0) begin end
`endif
  endtask

  function automatic vec_t mk(input string name, input logic stall,
      input logic a_v, input logic [4:0] a_addr, input logic [31:0] a_data,
      input logic b_v, input logic [4:0] b_addr, input logic [31:0] b_data,
      input logic [4:0] fwd_addr, input logic e_a_rdy, input logic e_b_rdy,
      input logic e_wren, input logic [4:0] e_addr, input logic [31:0] e_data,
      input logic [31:0] e_pend, input logic e_full, input logic e_empty,
      input logic e_hit, input logic [31:0] e_fwd);
    vec_t v;
    v.name = name; v.stall = stall;
    v.a_v = a_v; v.a_addr = a_addr; v.a_data = a_data;
    v.b_v = b_v; v.b_addr = b_addr; v.b_data = b_data;
    v.fwd_addr = fwd_addr; v.e_a_rdy = e_a_rdy; v.e_b_rdy = e_b_rdy;
    v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data; v.e_pend = e_pend;
    v.e_full = e_full; v.e_empty = e_empty; v.e_hit = e_hit; v.e_fwd = e_fwd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    @(negedge clk);
    drive(v.stall, v.a_v, v.a_addr, v.a_data, v.b_v, v.b_addr, v.b_data, v.fwd_addr);
    #2;
    p = $sformatf("%s[%0d]", v.name, idx);
    check({p, ".a_ready"}, 32'(bus.o_a_ready), 32'(v.e_a_rdy));
    check({p, ".b_ready"}, 32'(bus.o_b_ready), 32'(v.e_b_rdy));
    check({p, ".wren"},    32'(bus.o_rd_wren), 32'(v.e_wren));
    check({p, ".addr"},    32'(bus.o_rd_addr), 32'(v.e_addr));
    check({p, ".data"},    bus.o_rd_data,      v.e_data);
    check({p, ".pending"}, bus.o_pending,      v.e_pend);
    check({p, ".full"},    32'(bus.o_full),    32'(v.e_full));
    check({p, ".empty"},   32'(bus.o_empty),   32'(v.e_empty));
`ifdef WB_ARBITER_FWD_EN
    check({p, ".fwd_hit"},  32'(bus.o_fwd_hit), 32'(v.e_hit));
    check({p, ".fwd_data"}, bus.o_fwd_data,     v.e_fwd);
`endif
  endtask

  initial begin
    // Cycle-ordered table; each row is one clock and state carries row to row.
    //            name      stl a  aadr  adata         b  badr bdata    fwd  ar br we wadr wdata         pend        fu em hit fwd
    vecs.push_back(mk("idle",    0, 0, 0, 32'h0,        0, 0, 32'h0,  0,   0, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("bypass",  0, 1, 5, 32'h12345678, 0, 0, 32'h0,  0,   1, 0, 1, 5, 32'h12345678, 32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("x0drop",  0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("b_only",  0, 0, 0, 32'h0,        1, 9, 32'h99, 0,   0, 1, 1, 9, 32'h99,       32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("fill",    1, 1, 1, 32'h101,      0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("fill",    1, 1, 2, 32'h102,      0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'h2,      0, 0, 0, 32'h0));
    vecs.push_back(mk("fill",    1, 1, 3, 32'h103,      0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'h6,      0, 0, 0, 32'h0));
    vecs.push_back(mk("fill",    1, 1, 4, 32'h104,      0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'hE,      0, 0, 0, 32'h0));
    vecs.push_back(mk("held",    1, 1, 5, 32'h105,      0, 0, 32'h0,  0,   0, 0, 0, 0, 32'h0,        32'h1E,     1, 0, 0, 32'h0));
    vecs.push_back(mk("x0full",  1, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h0,        32'h1E,     1, 0, 0, 32'h0));
    vecs.push_back(mk("release", 0, 1, 5, 32'h105,      0, 0, 32'h0,  0,   0, 0, 1, 1, 32'h101,      32'h1E,     1, 0, 0, 32'h0));
    vecs.push_back(mk("enq_deq", 0, 1, 5, 32'h105,      0, 0, 32'h0,  0,   1, 0, 1, 2, 32'h102,      32'h1C,     0, 0, 0, 32'h0));
    vecs.push_back(mk("enq_deq", 0, 1, 6, 32'h106,      0, 0, 32'h0,  0,   1, 0, 1, 3, 32'h103,      32'h38,     0, 0, 0, 32'h0));
    vecs.push_back(mk("drain",   0, 0, 0, 32'h0,        0, 0, 32'h0,  0,   0, 0, 1, 4, 32'h104,      32'h70,     0, 0, 0, 32'h0));
    vecs.push_back(mk("drain",   0, 0, 0, 32'h0,        0, 0, 32'h0,  0,   0, 0, 1, 5, 32'h105,      32'h60,     0, 0, 0, 32'h0));
    vecs.push_back(mk("drain",   0, 0, 0, 32'h0,        0, 0, 32'h0,  0,   0, 0, 1, 6, 32'h106,      32'h40,     0, 0, 0, 32'h0));
    vecs.push_back(mk("drained", 0, 0, 0, 32'h0,        0, 0, 32'h0,  0,   0, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("dup",     1, 1, 7, 32'hAA,       0, 0, 32'h0,  7,   1, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));
    vecs.push_back(mk("dup",     1, 1, 7, 32'hBB,       0, 0, 32'h0,  7,   1, 0, 0, 0, 32'h0,        32'h80,     0, 0, 1, 32'hAA));
    vecs.push_back(mk("dup",     1, 0, 0, 32'h0,        0, 0, 32'h0,  7,   0, 0, 0, 0, 32'h0,        32'h80,     0, 0, 1, 32'hBB));
    vecs.push_back(mk("dup_wr",  0, 0, 0, 32'h0,        0, 0, 32'h0,  8,   0, 0, 1, 7, 32'hAA,       32'h80,     0, 0, 0, 32'h0));
    vecs.push_back(mk("dup_wr",  0, 0, 0, 32'h0,        0, 0, 32'h0,  7,   0, 0, 1, 7, 32'hBB,       32'h80,     0, 0, 1, 32'hBB));
    vecs.push_back(mk("dup_end", 0, 0, 0, 32'h0,        0, 0, 32'h0,  7,   0, 0, 0, 0, 32'h0,        32'h0,      0, 1, 0, 32'h0));

    // Reset with both producers asserting: nothing may be accepted or written.
    rst_n = 1'b0;
    drive(0, 1, 3, 32'h33, 1, 4, 32'h44, 0);
    #2;
    check("reset.a_ready", 32'(bus.o_a_ready), 32'h0);
    check("reset.b_ready", 32'(bus.o_b_ready), 32'h0);
    check("reset.wren",    32'(bus.o_rd_wren), 32'h0);
    check("reset.addr",    32'(bus.o_rd_addr), 32'h0);
    check("reset.data",    bus.o_rd_data,      32'h0);
    check("reset.pending", bus.o_pending,      32'h0);
    check("reset.full",    32'(bus.o_full),    32'h0);
    check("reset.empty",   32'(bus.o_empty),   32'h1);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Starvation: A and B valid every cycle, B holds its result until granted.
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      exp_b = (i % 5 == 4);
      exp_q.push_back(exp_b ? 5'd11 : 5'd10);
      @(negedge clk);
      drive(0, 1, 10, 32'(i), 1, 11, 32'hB0 + 32'(i / 5), 0);
      #2;
      check($sformatf("starve[%0d].a_ready", i), 32'(bus.o_a_ready), 32'(!exp_b));
      check($sformatf("starve[%0d].b_ready", i), 32'(bus.o_b_ready), 32'(exp_b));
      check($sformatf("starve[%0d].wren", i),    32'(bus.o_rd_wren), 32'h1);
      check($sformatf("starve[%0d].addr", i),    32'(bus.o_rd_addr), 32'(exp_q.pop_front()));
      check($sformatf("starve[%0d].data", i),    bus.o_rd_data,
            exp_b ? 32'hB0 + 32'(i / 5) : 32'(i));
    end

    // Mid-operation reset with three buffered writes.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1, 5'(20 + i), 32'h200 + 32'(i), 0, 0, 32'h0, 0);
    end
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    #2;
    check("midrst.pre_pending", bus.o_pending, 32'h0070_0000);
    check("midrst.pre_empty",   32'(bus.o_empty), 32'h0);
    rst_n = 1'b0;
    drive(0, 1, 12, 32'hC, 0, 0, 32'h0, 0);
    #1;
    check("midrst.wren",    32'(bus.o_rd_wren), 32'h0);
    check("midrst.a_ready", 32'(bus.o_a_ready), 32'h0);
    check("midrst.addr",    32'(bus.o_rd_addr), 32'h0);
    check("midrst.pending", bus.o_pending,      32'h0);
    check("midrst.full",    32'(bus.o_full),    32'h0);
    check("midrst.empty",   32'(bus.o_empty),   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      #2;
      check($sformatf("postrst[%0d].wren", i),  32'(bus.o_rd_wren), 32'h0);
      check($sformatf("postrst[%0d].empty", i), 32'(bus.o_empty),   32'h1);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back initiator for the integer register file: the block that drives the register file's single write port (rd address, rd data, write enable).
- Merges completed results from two producers:
  - ALU, port A, high priority.
  - Load/store/multi-cycle unit, port B.
- Buffers results in a small in-order FIFO while the write port is stalled.
- Exports a pending-write scoreboard so the decode stage can detect RAW hazards on buffered writes.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
STARVE_MAX, 4, consecutive lost arbitration cycles after which port B gets priority for one cycle; minimum 1.

Ports:
i_clk  input  1  global clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_a_valid  input  1  ALU result valid
i_a_addr  input  5  ALU destination register
i_a_data  input  32  ALU result
o_a_ready  output  1  port A accepted this cycle
i_b_valid  input  1  LSU result valid
i_b_addr  input  5  LSU destination register
i_b_data  input  32  LSU result
o_b_ready  output  1  port B accepted this cycle
i_stall  input  1  write port unavailable this cycle
o_rd_wren  output  1  register file write enable
o_rd_addr  output  5  register file write address
o_rd_data  output  32  register file write data
o_pending  output  32  bit r set while register r has an entry in the FIFO
o_full  output  1  FIFO holds DEPTH entries
o_empty  output  1  FIFO holds 0 entries

Behaviour:
- Reset: asynchronous, active-low, one clock i_clk. While i_reset=0:
  - Pointers, count and starve counter are 0; FIFO entries are invalid.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_pending=0, o_full=0, o_empty=1, o_a_ready=0, o_b_ready=0.
  - Reset mid-operation discards all buffered writes; nothing is written.
- Arbitration, one grant per cycle:
  - A wins by default.
  - B wins when the starve counter equals STARVE_MAX and B is valid.
  - The starve counter increments when B is valid and loses; it clears when B is granted or B is not valid.
  - The losing port sees ready=0 and must hold its valid, addr and data.
- Acceptance: the winner is accepted (ready=1) when FIFO is not full, or when a bypass applies. Ready is combinational from valid, FIFO state and i_stall.
- Bypass, zero latency: when FIFO is empty and i_stall=0, the accepted winner drives o_rd_wren/o_rd_addr/o_rd_data in the same cycle. Nothing is enqueued.
- Enqueue: when FIFO is non-empty or i_stall=1, the accepted winner is written at the tail on the clock edge.
- Dequeue: when FIFO is non-empty and i_stall=0, the head drives the write port combinationally and is popped on the clock edge.
- Enqueue and dequeue can happen in the same cycle. When full, no enqueue occurs, even if a dequeue happens that cycle; ready must not depend on dequeue.
- Ordering: register-file writes are issued in acceptance order. A new result never overtakes a buffered one, because bypass is allowed only when FIFO is empty.
- x0 writes: a valid result with addr=0 is accepted (ready=1) and dropped.
  - It is not enqueued and o_rd_wren is not asserted.
  - It still counts as the grant for that cycle.
- i_stall=1: o_rd_wren=0; FIFO contents hold; enqueue continues until full.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. o_full is count==DEPTH; o_empty is count==0.
- o_pending: combinational OR over valid entries of onehot(entry addr). Bit 0 is always 0. The bit stays set while any entry for that register remains, even when the register appears more than once.
- Idle outputs: when no write occurs, o_rd_wren=0 and o_rd_addr/o_rd_data=0.

Optional Feature:
- Macro: WB_ARBITER_FWD_EN.
- Defined: adds ports i_fwd_addr input 5, o_fwd_hit output 1, o_fwd_data output 32.
  - o_fwd_hit=1 when any valid FIFO entry matches i_fwd_addr and i_fwd_addr is not 0.
  - o_fwd_data is the data of the youngest matching entry; it is combinational.
  - With no hit, o_fwd_data=0.
- Undefined: these ports do not exist; decode stalls on o_pending instead.

Decomposition:
- Package wb_pkg holds:
  - typedef wb_req_t: packed struct {logic [4:0] addr; logic [31:0] data;}.
  - localparam REG_COUNT=32.
- Sub-module wb_fifo: DEPTH-entry FIFO of wb_req_t, with push/pop/full/empty and per-entry valid and addr exposure for scoreboard and forwarding. The arbiter, starve counter and bypass mux stay in wb_arbiter.

Test Plan:
- Reset: FIFO holds 3 entries; assert i_reset=0 mid-cycle -> all outputs 0 immediately, o_empty=1, no write after release.
- Bypass: empty, i_stall=0, A valid addr=5 data=0x12345678 -> same cycle o_rd_wren=1, addr=5, data=0x12345678, o_a_ready=1, o_pending=0.
- Stall fill: i_stall=1, A writes addr 1..4 -> accepted for 4 cycles, o_full=1, o_pending=0x1E. The 5th is held with o_a_ready=0. Release stall -> writes 1,2,3,4 in order on consecutive cycles.
- Starvation: A and B valid every cycle, STARVE_MAX=4, i_stall=0 -> grant pattern A,A,A,A,B repeating.
- x0 drop: A valid addr=0 data=0xFFFFFFFF -> o_a_ready=1, o_rd_wren=0, FIFO unchanged.
- Forward (WB_ARBITER_FWD_EN): stalled FIFO holds addr 7 with 0xAA, then addr 7 with 0xBB -> i_fwd_addr=7 gives o_fwd_hit=1, o_fwd_data=0xBB. i_fwd_addr=8 gives o_fwd_hit=0.
